// File: rtl/game_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// game_ctrl_fsm
//   Top-level game sequencer in front of the LCD pixel composer. Runs the
//   IDLE/PLAY/PAUSE/OVER state machine, accumulates the score and keeps the
//   best score since reset.
//
//   Optional feature macro: GAME_CTRL_PAUSE_EN
//     defined     : PAUSE state and pause_btn are active
//     not defined : pause_btn is ignored, PAUSE is unreachable
//
// Ports
//   clk             in   system clock (same as LCD pixel path)
//   rst_n           in   asynchronous active-low reset
//   frame_tick      in   one-cycle pulse per LCD frame
//   start_btn       in   start button level (debounced upstream)
//   pause_btn       in   pause button level (debounced upstream)
//   finished [2:0]  in   0 running, 1 win, other lose
//   plus_score[1:0] in   units of SCORE_UNIT to add this cycle
//   enable_game     out  0 holds sprites at reset positions
//   freeze          out  1 stops sprite motion
//   show_game_start out  title overlay
//   show_game_over  out  game-over overlay
//   score   [13:0]  out  current score
//   high_score[13:0]out  best score since reset
//   game_won        out  1 in OVER when the game ended on finished==1
//   state_o [1:0]   out  debug state: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
//
// state | meaning
// IDLE  | title screen, sprites held in reset
// PLAY  | game running, score accumulates
// PAUSE | sprites frozen, score input ignored
// OVER  | game-over screen, restart locked out for OVER_LOCK_FRM frames
// ----------------------------------------------------------------------------
module game_ctrl_fsm #(
   parameter int SCORE_MAX     = 9999,
   parameter int SCORE_UNIT    = 10,
   parameter int OVER_LOCK_FRM = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        start_btn,
   input  logic        pause_btn,
   input  logic [2:0]  finished,
   input  logic [1:0]  plus_score,
   output logic        enable_game,
   output logic        freeze,
   output logic        show_game_start,
   output logic        show_game_over,
   output logic [13:0] score,
   output logic [13:0] high_score,
   output logic        game_won,
   output logic [1:0]  state_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PLAY  = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_OVER  = 2'd3;

   localparam int          LOCK_W   = $clog2(OVER_LOCK_FRM + 1);
   localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(OVER_LOCK_FRM);
   localparam logic [14:0] MAX15    = 15'(SCORE_MAX);
   localparam logic [14:0] UNIT15   = 15'(SCORE_UNIT);

   logic [1:0]        state, next_state;
   logic [LOCK_W-1:0] lock_cnt;
   logic              start_q;
   logic              start_rise, pause_rise;
   logic [14:0]       sum15;
   logic [13:0]       score_next;
   logic              en_d, frz_d, ss_d, so_d;

   assign start_rise = start_btn & ~start_q;

`ifdef GAME_CTRL_PAUSE_EN
   logic pause_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pause_q <= 1'b0;
      else        pause_q <= pause_btn;
   end
   assign pause_rise = pause_btn & ~pause_q;
`else
   logic unused_pause_btn;
   assign unused_pause_btn = pause_btn;
   assign pause_rise       = 1'b0;
`endif

   // Sum is carried at 15 bits so 9999 + 30 cannot wrap before saturation.
   always_comb begin
      sum15      = {1'b0, score} + 15'(plus_score) * UNIT15;
      score_next = score;
      if (state == S_PLAY && plus_score != 2'd0)
         score_next = (sum15 > MAX15) ? MAX15[13:0] : sum15[13:0];
   end

   // State register, registered outputs and datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         enable_game     <= 1'b0;
         freeze          <= 1'b0;
         show_game_start <= 1'b1;
         show_game_over  <= 1'b0;
         score           <= '0;
         high_score      <= '0;
         game_won        <= 1'b0;
         lock_cnt        <= '0;
         start_q         <= 1'b0;
      end else begin
         state           <= next_state;
         enable_game     <= en_d;
         freeze          <= frz_d;
         show_game_start <= ss_d;
         show_game_over  <= so_d;
         start_q         <= start_btn;

         if (state == S_IDLE && start_rise) begin
            score    <= '0;
            game_won <= 1'b0;
         end else begin
            score    <= score_next;
         end

         // The final hit counts toward the high score.
         if (state == S_PLAY && finished != 3'd0) begin
            game_won   <= (finished == 3'd1);
            lock_cnt   <= LOCK_LOAD;
            high_score <= (score_next > high_score) ? score_next : high_score;
         end else if (state == S_OVER && frame_tick && lock_cnt != '0) begin
            lock_cnt   <= lock_cnt - 1'b1;
         end
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (start_rise) next_state = S_PLAY;
         S_PLAY: begin
            if (finished != 3'd0)  next_state = S_OVER;
            else if (pause_rise)   next_state = S_PAUSE;
         end
         S_PAUSE: if (pause_rise || start_rise) next_state = S_PLAY;
         S_OVER:  if (start_rise && lock_cnt == '0) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state, so outputs change with state_o
   always_comb begin
      en_d  = 1'b0;
      frz_d = 1'b0;
      ss_d  = 1'b0;
      so_d  = 1'b0;
      case (next_state)
         S_IDLE:  ss_d = 1'b1;
         S_PLAY:  en_d = 1'b1;
         S_PAUSE: begin en_d = 1'b1; frz_d = 1'b1; end
         S_OVER:  begin en_d = 1'b1; frz_d = 1'b1; so_d = 1'b1; end
         default: ss_d = 1'b1;
      endcase
   end

   assign state_o = state;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
module tb_game_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_tick = 1'b0;
   logic        start_btn = 1'b0;
   logic        pause_btn = 1'b0;
   logic [2:0]  finished = 3'd0;
   logic [1:0]  plus_score = 2'd0;
   logic        enable_game, freeze, show_game_start, show_game_over, game_won;
   logic [13:0] score, high_score;
   logic [1:0]  state_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   game_ctrl_fsm dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_tick      (frame_tick),
      .start_btn       (start_btn),
      .pause_btn       (pause_btn),
      .finished        (finished),
      .plus_score      (plus_score),
      .enable_game     (enable_game),
      .freeze          (freeze),
      .show_game_start (show_game_start),
      .show_game_over  (show_game_over),
      .score           (score),
      .high_score      (high_score),
      .game_won        (game_won),
      .state_o         (state_o)
   );

   typedef struct {
      logic        start, pause;
      logic [2:0]  fin;
      logic [1:0]  plus;
      logic        tick;
      logic [1:0]  st;
      logic [13:0] sc, hi;
      logic        en, fz, ss, so, won;
   } vec_t;

   function automatic vec_t mk(logic s, logic p, logic [2:0] f, logic [1:0] ps, logic t,
                               logic [1:0] st, logic [13:0] sc, logic [13:0] hi,
                               logic en, logic fz, logic ss, logic so, logic won);
      vec_t v;
      v.start = s; v.pause = p; v.fin = f; v.plus = ps; v.tick = t;
      v.st = st; v.sc = sc; v.hi = hi;
      v.en = en; v.fz = fz; v.ss = ss; v.so = so; v.won = won;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic chk_all(input vec_t v, input string nm);
      chk({nm, ".state"},      14'(state_o),         14'(v.st));
      chk({nm, ".score"},      score,                v.sc);
      chk({nm, ".high"},       high_score,           v.hi);
      chk({nm, ".enable"},     14'(enable_game),     14'(v.en));
      chk({nm, ".freeze"},     14'(freeze),          14'(v.fz));
      chk({nm, ".show_start"}, 14'(show_game_start), 14'(v.ss));
      chk({nm, ".show_over"},  14'(show_game_over),  14'(v.so));
      chk({nm, ".won"},        14'(game_won),        14'(v.won));
   endtask

   task automatic drive(input logic s, input logic p, input logic [2:0] f,
                        input logic [1:0] ps, input logic t);
      start_btn = s; pause_btn = p; finished = f; plus_score = ps; frame_tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input string nm);
      drive(v.start, v.pause, v.fin, v.plus, v.tick);
      chk_all(v, nm);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 2'd0, 1'b1);
   endtask

   vec_t tbl[7];

   initial begin
      //         st  p  fin  ps  t   st  score  high en fz ss so won
      tbl[0] = mk(1, 0, 3'd0, 2'd0, 0, 2'd1, 14'd0,  14'd0,  1, 0, 0, 0, 0);
      tbl[1] = mk(1, 0, 3'd0, 2'd2, 0, 2'd1, 14'd20, 14'd0,  1, 0, 0, 0, 0);
      tbl[2] = mk(0, 0, 3'd0, 2'd3, 0, 2'd1, 14'd50, 14'd0,  1, 0, 0, 0, 0);
      tbl[3] = mk(0, 0, 3'd0, 2'd0, 0, 2'd1, 14'd50, 14'd0,  1, 0, 0, 0, 0);
      tbl[4] = mk(0, 0, 3'd2, 2'd1, 0, 2'd3, 14'd60, 14'd60, 1, 1, 0, 1, 0);
      tbl[5] = mk(0, 0, 3'd0, 2'd3, 0, 2'd3, 14'd60, 14'd60, 1, 1, 0, 1, 0);
      tbl[6] = mk(1, 0, 3'd0, 2'd0, 0, 2'd3, 14'd60, 14'd60, 1, 1, 0, 1, 0);

      #12;
      chk_all(mk(0, 0, 3'd0, 2'd0, 0, 2'd0, 14'd0, 14'd0, 0, 0, 1, 0, 0), "reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all(mk(0, 0, 3'd0, 2'd0, 0, 2'd0, 14'd0, 14'd0, 0, 0, 1, 0, 0), "idle_hold");

      for (int i = 0; i < 7; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Restart lockout: 5 ticks, then 119 ticks, both too early
      drive(0, 0, 3'd0, 2'd0, 0);
      ticks(5);
      apply(mk(1, 0, 3'd0, 2'd0, 0, 2'd3, 14'd60, 14'd60, 1, 1, 0, 1, 0), "lock5");
      drive(0, 0, 3'd0, 2'd0, 0);
      ticks(114);
      apply(mk(1, 0, 3'd0, 2'd0, 0, 2'd3, 14'd60, 14'd60, 1, 1, 0, 1, 0), "lock119");
      drive(0, 0, 3'd0, 2'd0, 0);
      ticks(1);
      apply(mk(1, 0, 3'd0, 2'd0, 0, 2'd0, 14'd60, 14'd60, 0, 0, 1, 0, 0), "lock120");
      drive(0, 0, 3'd0, 2'd0, 0);
      apply(mk(1, 0, 3'd0, 2'd0, 0, 2'd1, 14'd0, 14'd60, 1, 0, 0, 0, 0), "restart");
      drive(0, 0, 3'd0, 2'd0, 0);

`ifdef GAME_CTRL_PAUSE_EN
      apply(mk(0, 1, 3'd0, 2'd0, 0, 2'd2, 14'd0, 14'd60, 1, 1, 0, 0, 0), "pause_in");
      apply(mk(0, 1, 3'd0, 2'd3, 0, 2'd2, 14'd0, 14'd60, 1, 1, 0, 0, 0), "pause_noscore");
      apply(mk(0, 0, 3'd0, 2'd0, 0, 2'd2, 14'd0, 14'd60, 1, 1, 0, 0, 0), "pause_hold");
      apply(mk(0, 1, 3'd0, 2'd0, 0, 2'd1, 14'd0, 14'd60, 1, 0, 0, 0, 0), "pause_out");
`else
      apply(mk(0, 1, 3'd0, 2'd0, 0, 2'd1, 14'd0, 14'd60, 1, 0, 0, 0, 0), "pause_ignored");
      apply(mk(0, 0, 3'd0, 2'd0, 0, 2'd1, 14'd0, 14'd60, 1, 0, 0, 0, 0), "pause_rel");
`endif
      apply(mk(1, 0, 3'd0, 2'd0, 0, 2'd1, 14'd0, 14'd60, 1, 0, 0, 0, 0), "start_in_play");
      drive(0, 0, 3'd0, 2'd0, 0);

      // Saturation: 333 * 30 = 9990, then +30 clips to 9999
      for (int i = 0; i < 333; i++) drive(0, 0, 3'd0, 2'd3, 0);
      chk("sat.pre", score, 14'd9990);
      apply(mk(0, 0, 3'd0, 2'd3, 0, 2'd1, 14'd9999, 14'd60, 1, 0, 0, 0, 0), "sat.clip");
      apply(mk(0, 0, 3'd0, 2'd1, 0, 2'd1, 14'd9999, 14'd60, 1, 0, 0, 0, 0), "sat.hold");

      apply(mk(0, 0, 3'd1, 2'd0, 0, 2'd3, 14'd9999, 14'd9999, 1, 1, 0, 1, 1), "win");

      // Asynchronous reset mid-game takes effect without a clock edge
      #2;
      rst_n = 1'b0;
      #1;
      chk_all(mk(0, 0, 3'd0, 2'd0, 0, 2'd0, 14'd0, 14'd0, 0, 0, 1, 0, 0), "async_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
